// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction buffer: a DEPTH-entry circular queue of (pc, inst)
// pairs with valid/ready on both sides. A flush drops everything. Decode sees a bubble when the queue is empty.
module inst_fetch_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter int                DEPTH       = 4,
  parameter logic [INST_W-1:0] BUBBLE_INST = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_pc,
  input  logic [INST_W-1:0]            in_inst,
  input  logic                         flush_i,
  input  logic                         stall_i,
  output logic                         out_valid,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [INST_W-1:0]            out_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [PW-1:0]  wp, rp;
  logic           full, empty, enq, deq;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  // in_ready depends only on registered count and rst, never on stall/flush.
  assign in_ready  = !rst && !full;
  assign out_valid = !empty;
  assign enq       = in_valid & in_ready & !flush_i;
  assign deq       = out_valid & !stall_i & !flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq) wp <= wp + PW'(1);
      if (deq) rp <= rp + PW'(1);
      if (enq && !deq)      count <= count + CW'(1);
      else if (!enq && deq) count <= count - CW'(1);
    end
  end

  // Storage is never reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (enq) mem[wp] <= '{pc: in_pc, inst: in_inst};
  end

  assign head     = mem[rp];
  assign out_pc   = out_valid ? head.pc   : '0;
  assign out_inst = out_valid ? head.inst : BUBBLE_INST;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Two queue instances (DEPTH=4 bubble 0, DEPTH=2 bubble 0x13) share one fetch-side
// stimulus stream; each is checked against its own queue-based reference model.
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, flush_i = 1'b0, stall_i = 1'b0;
  logic [31:0] in_pc = '0, in_inst = '0;

  logic        rdy4, vld4, rdy2, vld2;
  logic [31:0] pc4, inst4, pc2, inst2;
  logic [2:0]  cnt4;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  inst_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .BUBBLE_INST(32'h0)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_pc(in_pc),
    .in_inst(in_inst), .flush_i(flush_i), .stall_i(stall_i), .out_valid(vld4),
    .out_pc(pc4), .out_inst(inst4), .count(cnt4));

  inst_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(2), .BUBBLE_INST(32'h13)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_pc(in_pc),
    .in_inst(in_inst), .flush_i(flush_i), .stall_i(stall_i), .out_valid(vld2),
    .out_pc(pc2), .out_inst(inst2), .count(cnt2));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q4[$], q2[$];
  int   total = 0, bad = 0, timeouts = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model updates at each rising edge, compares on the falling edge.
  initial begin
    int s;
    while (!done) begin
      @(posedge clk);
      s = q4.size();
      if (rst || flush_i) q4.delete();
      else begin
        if (s > 0 && !stall_i) q4.delete(0);
        if (in_valid && s < 4) q4.push_back('{in_pc, in_inst});
      end
      s = q2.size();
      if (rst || flush_i) q2.delete();
      else begin
        if (s > 0 && !stall_i) q2.delete(0);
        if (in_valid && s < 2) q2.push_back('{in_pc, in_inst});
      end

      @(negedge clk);
      chk("count4",    32'(cnt4), 32'(q4.size()));
      chk("valid4",    32'(vld4), 32'(q4.size() > 0));
      chk("ready4",    32'(rdy4), 32'(!rst && q4.size() < 4));
      if (q4.size() > 0) begin
        chk("pc4",   pc4,   q4[0].pc);
        chk("inst4", inst4, q4[0].inst);
      end else begin
        chk("pc4_empty",   pc4,   32'h0);
        chk("inst4_empty", inst4, 32'h0);
      end
      chk("count2",    32'(cnt2), 32'(q2.size()));
      chk("valid2",    32'(vld2), 32'(q2.size() > 0));
      chk("ready2",    32'(rdy2), 32'(!rst && q2.size() < 2));
      if (q2.size() > 0) begin
        chk("pc2",   pc2,   q2[0].pc);
        chk("inst2", inst2, q2[0].inst);
      end else begin
        chk("pc2_empty",   pc2,   32'h0);
        chk("inst2_empty", inst2, 32'h13);
      end
    end
    chk("stim_timeout", 32'(timeouts), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the pair until the DEPTH=4 instance accepts it (bounded).
  task automatic push(input logic [31:0] pc, input logic [31:0] inst);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = rdy4;
      @(posedge clk);
      #1;
    end
    if (!ok) timeouts++;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] insts [4];
    insts = '{32'h13, 32'h93, 32'h113, 32'h193};

    // reset held with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; in_pc = 32'hdead; in_inst = 32'hbeef;
    cyc(2);
    rst = 1'b0; in_valid = 1'b0;
    cyc(1);

    // fill under stall, then a fifth entry that must be refused
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(4*i), insts[i]);
    in_valid = 1'b1; in_pc = 32'h110; in_inst = 32'h213;
    cyc(3);

    // release stall, keep feeding: drain order and pointer wrap
    stall_i = 1'b0;
    for (int i = 4; i < 9; i++) push(32'h100 + 32'(4*i), 32'h13 + 32'(i*128));
    cyc(8);

    // flush with a simultaneous enqueue attempt
    stall_i = 1'b1;
    push(32'h300, 32'h1); push(32'h304, 32'h2); push(32'h308, 32'h3);
    in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'hbad; flush_i = 1'b1;
    cyc(1);
    flush_i = 1'b0; in_valid = 1'b0;
    cyc(3);
    stall_i = 1'b0;
    cyc(2);

    // steady state: simultaneous enq/deq for 10 cycles
    stall_i = 1'b1;
    push(32'h400, 32'h40); push(32'h404, 32'h41);
    stall_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 32'h408 + 32'(4*i); in_inst = 32'h42 + 32'(i);
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(6);

    // randomized traffic with occasional flush and mid-operation reset
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom % 4) != 0;
      stall_i  = ($urandom % 3) == 0;
      flush_i  = ($urandom % 32) == 0;
      rst      = ($urandom % 64) == 0;
      in_pc    = $urandom;
      in_inst  = $urandom;
      cyc(1);
    end
    rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; in_valid = 1'b0;
    cyc(6);
    done = 1'b1;
  end
endmodule
